// File: rtl/float_div_iter.sv
// float_div_iter: iterative IEEE-754 single-precision divider.
// Radix-2 restoring divide, one quotient bit per cycle (24 + guard + round),
// round to nearest / ties to even, valid/ready handshake on both sides.
// Optional build macro FDIV_SUBNORMAL_EN: when defined, subnormal operands are
// normalized in a NORM state and tiny results are denormalized with gradual
// underflow; when undefined, subnormal inputs read as zero and tiny results
// flush to signed zero.
module float_div_iter (
    input  logic        clk,
    input  logic        clrn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] q,
    output logic [4:0]  flags
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
`ifdef FDIV_SUBNORMAL_EN
        NORM  = 3'd1,
`endif
        DIV   = 3'd2,
        ROUND = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [4:0] LAST_ITER = 5'd25;

    state_t state, next_state;

    // Datapath state
    logic               sign_r;
    logic signed [9:0]  exp_r;
    logic [23:0]        mb_r;
    logic [25:0]        rem_r;
    logic [25:0]        quo_r;
    logic [4:0]         cnt_r;
`ifdef FDIV_SUBNORMAL_EN
    logic [23:0]        ma_r;
`endif

    // Operand decode
    logic        sign_in;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, special;
    logic [31:0] spec_q;
    logic [4:0]  spec_flags;
    logic [23:0] ma_in, mb_in;
    logic [9:0]  exp_in;

    // Divide step
    logic        ge;
    logic [25:0] rem_sel, rem_n;

    // Rounding
    logic        sticky, g, r, rup, inexact;
    logic [23:0] mant;
    logic [24:0] sum;
    logic [22:0] mant_post;
    logic signed [9:0] e_post;
    logic [31:0] res_q;
    logic [4:0]  res_flags;

    // Registered-output next values
    logic [31:0] q_d;
    logic [4:0]  flags_d;
    logic        out_valid_d, in_ready_d;

    // Dividend pre-shift so the quotient always lands in [1,2)
    function automatic logic [25:0] pre_rem(input logic [23:0] ma, input logic [23:0] mb);
        return (ma < mb) ? {1'b0, ma, 1'b0} : {2'b00, ma};
    endfunction

`ifdef FDIV_SUBNORMAL_EN
    logic [4:0]  lza, lzb;
    logic [23:0] ma_n, mb_n;
    logic [9:0]  exp_n;
    logic [9:0]  sh;
    logic [25:0] v;
    logic        st, g_s, r_s, rup_s, nx_s;
    logic [23:0] sum_s;

    function automatic logic [4:0] lzc24(input logic [23:0] m);
        logic [4:0] n;
        logic       found;
        n     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 24; i++) begin
            if (!found) begin
                if (m[23 - i]) found = 1'b1;
                else           n = n + 5'd1;
            end
        end
        return n;
    endfunction

    // Left-normalize stored mantissas and fold the shift into the exponent
    always_comb begin
        lza   = lzc24(ma_r);
        lzb   = lzc24(mb_r);
        ma_n  = ma_r << lza;
        mb_n  = mb_r << lzb;
        exp_n = exp_r - {5'd0, lza} + {5'd0, lzb};
    end
`endif

    // Classify operands and resolve the special-operand result
    always_comb begin
        sign_in = a[31] ^ b[31];
        ea = a[30:23];
        eb = b[30:23];
        fa = a[22:0];
        fb = b[22:0];
        a_nan = (ea == 8'hff) && (fa != '0);
        b_nan = (eb == 8'hff) && (fb != '0);
        a_inf = (ea == 8'hff) && (fa == '0);
        b_inf = (eb == 8'hff) && (fb == '0);
`ifdef FDIV_SUBNORMAL_EN
        a_zero = (ea == '0) && (fa == '0);
        b_zero = (eb == '0) && (fb == '0);
        ma_in  = {ea != '0, fa};
        mb_in  = {eb != '0, fb};
        exp_in = {2'b00, (ea == '0) ? 8'd1 : ea} - {2'b00, (eb == '0) ? 8'd1 : eb} + 10'd127;
`else
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        ma_in  = {1'b1, fa};
        mb_in  = {1'b1, fb};
        exp_in = {2'b00, ea} - {2'b00, eb} + 10'd127;
`endif
        special    = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
        spec_q     = '0;
        spec_flags = '0;
        if (a_nan) begin
            spec_q = {sign_in, 8'hff, 1'b1, fa[21:0]};
        end else if (b_nan) begin
            spec_q = {sign_in, 8'hff, 1'b1, fb[21:0]};
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_q     = 32'h7FC00000;
            spec_flags = 5'b10000;
        end else if (a_inf) begin
            spec_q = {sign_in, 8'hff, 23'd0};
        end else if (b_zero) begin
            spec_q     = {sign_in, 8'hff, 23'd0};
            spec_flags = 5'b01000;
        end else begin
            spec_q = {sign_in, 31'd0};
        end
    end

    // One restoring-divide step
    always_comb begin
        ge      = (rem_r >= {2'b00, mb_r});
        rem_sel = ge ? (rem_r - {2'b00, mb_r}) : rem_r;
        rem_n   = rem_sel << 1;
    end

    // Round the finished quotient and pack the result
    always_comb begin
        sticky    = (rem_r != '0);
        mant      = quo_r[25:2];
        g         = quo_r[1];
        r         = quo_r[0];
        inexact   = g | r | sticky;
        rup       = g & (r | sticky | mant[0]);
        sum       = {1'b0, mant} + {24'd0, rup};
        e_post    = sum[24] ? (exp_r + 10'sd1) : exp_r;
        mant_post = sum[24] ? sum[23:1] : sum[22:0];
        res_q     = '0;
        res_flags = '0;
`ifdef FDIV_SUBNORMAL_EN
        // Denormalize the full quotient first so guard/round/sticky are taken
        // at the subnormal LSB, then round once.
        sh = 10'd1 - exp_r;
        v  = quo_r;
        st = sticky;
        for (int unsigned i = 0; i < 27; i++) begin
            if (10'(i) < sh) begin
                st = st | v[0];
                v  = v >> 1;
            end
        end
        g_s   = v[1];
        r_s   = v[0];
        rup_s = g_s & (r_s | st | v[2]);
        nx_s  = g_s | r_s | st;
        sum_s = v[25:2] + {23'd0, rup_s};
`endif
        if (exp_r <= 10'sd0) begin
`ifdef FDIV_SUBNORMAL_EN
            res_q     = {sign_r, 7'd0, sum_s[23], sum_s[22:0]};
            res_flags = {3'b000, nx_s, nx_s};
`else
            res_q     = {sign_r, 31'd0};
            res_flags = 5'b00011;
`endif
        end else if (e_post >= 10'sd255) begin
            res_q     = {sign_r, 8'hff, 23'd0};
            res_flags = 5'b00101;
        end else begin
            res_q     = {sign_r, e_post[7:0], mant_post};
            res_flags = {4'b0000, inexact};
        end
    end

    // State register
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (special) next_state = DONE;
`ifdef FDIV_SUBNORMAL_EN
                    else         next_state = NORM;
`else
                    else         next_state = DIV;
`endif
                end
            end
`ifdef FDIV_SUBNORMAL_EN
            NORM:    next_state = DIV;
`endif
            DIV:     if (cnt_r == LAST_ITER) next_state = ROUND;
            ROUND:   next_state = DONE;
            DONE:    if (out_valid && out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output next values; special results land in q at acceptance and
    // out_valid follows one cycle later so their latency is one cycle.
    always_comb begin
        q_d         = q;
        flags_d     = flags;
        out_valid_d = out_valid;
        case (state)
            IDLE: begin
                if (in_valid && special) begin
                    q_d     = spec_q;
                    flags_d = spec_flags;
                end
            end
            ROUND: begin
                q_d         = res_q;
                flags_d     = res_flags;
                out_valid_d = 1'b1;
            end
            DONE: begin
                if (!out_valid)    out_valid_d = 1'b1;
                else if (out_ready) out_valid_d = 1'b0;
            end
            default: ;
        endcase
        in_ready_d = (next_state == IDLE);
    end

    // Output registers
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            q         <= '0;
            flags     <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            q         <= q_d;
            flags     <= flags_d;
            out_valid <= out_valid_d;
            in_ready  <= in_ready_d;
        end
    end

    // Operand capture, normalization and divide iterations
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            sign_r <= 1'b0;
            exp_r  <= '0;
            mb_r   <= '0;
            rem_r  <= '0;
            quo_r  <= '0;
            cnt_r  <= '0;
`ifdef FDIV_SUBNORMAL_EN
            ma_r   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_r <= sign_in;
                        quo_r  <= '0;
                        cnt_r  <= '0;
                        mb_r   <= mb_in;
`ifdef FDIV_SUBNORMAL_EN
                        ma_r   <= ma_in;
                        exp_r  <= exp_in;
`else
                        rem_r  <= pre_rem(ma_in, mb_in);
                        exp_r  <= exp_in - {9'd0, (ma_in < mb_in)};
`endif
                    end
                end
`ifdef FDIV_SUBNORMAL_EN
                NORM: begin
                    mb_r  <= mb_n;
                    rem_r <= pre_rem(ma_n, mb_n);
                    exp_r <= exp_n - {9'd0, (ma_n < mb_n)};
                end
`endif
                DIV: begin
                    rem_r <= rem_n;
                    quo_r <= {quo_r[24:0], ge};
                    cnt_r <= (cnt_r == LAST_ITER) ? '0 : cnt_r + 5'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_float_div_iter.sv
// tb_float_div_iter: table-driven, scoreboard-checked bench for float_div_iter.
module tb_float_div_iter;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] q;
    logic [4:0]  flags;

    float_div_iter dut (
        .clk       (clk),
        .clrn      (clrn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .flags     (flags)
    );

    always #5 clk = ~clk;

`ifdef FDIV_SUBNORMAL_EN
    localparam int LAT_N = 28;
`else
    localparam int LAT_N = 27;
`endif

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [4:0]  f;
        int          lat;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] q;
        logic [4:0]  f;
        int          lat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [31:0] va, input logic [31:0] vb,
                                input logic [31:0] vq, input logic [4:0] vf, input int vl);
        vec_t v;
        v.name = n; v.a = va; v.b = vb; v.q = vq; v.f = vf; v.lat = vl;
        return v;
    endfunction

    // Present operands once in_ready is seen, push the expectation at acceptance
    task automatic issue(input logic [31:0] va, input logic [31:0] vb, input exp_t e);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) chk({e.name, ".in_ready_timeout"}, 32'(in_ready), 32'd1);
        a = va;
        b = vb;
        in_valid = 1'b1;
        @(posedge clk);
        sb.push_back(e);
        #1;
        // Junk operands with in_valid still high must be ignored while busy
        a = $urandom;
        b = $urandom;
    endtask

    // Count cycles to out_valid, then pop and compare against the scoreboard
    task automatic collect();
        int   cyc = 0;
        exp_t e;
        while (!out_valid && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            in_valid = 1'b0;
        end
        in_valid = 1'b0;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk({e.name, ".latency"}, 32'(cyc), 32'(e.lat));
            chk({e.name, ".q"}, q, e.q);
            chk({e.name, ".flags"}, 32'(flags), 32'(e.f));
        end
        if (out_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        exp_t e;
        int   seen;

        vecs.push_back(mk("6/2",     32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, LAT_N));
        vecs.push_back(mk("1/3",     32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, LAT_N));
        vecs.push_back(mk("1/0",     32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 1));
        vecs.push_back(mk("0/0",     32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000, 1));
        vecs.push_back(mk("ovf",     32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 5'b00101, LAT_N));
`ifdef FDIV_SUBNORMAL_EN
        vecs.push_back(mk("tiny",    32'h00800000, 32'h40000000, 32'h00400000, 5'b00000, LAT_N));
        vecs.push_back(mk("sub/1",   32'h00400000, 32'h3F800000, 32'h00400000, 5'b00000, LAT_N));
`else
        vecs.push_back(mk("tiny",    32'h00800000, 32'h40000000, 32'h00000000, 5'b00011, LAT_N));
        vecs.push_back(mk("sub/1",   32'h00400000, 32'h3F800000, 32'h00000000, 5'b00000, 1));
`endif
        vecs.push_back(mk("nan_a",   32'h7FC00001, 32'h3F800000, 32'h7FC00001, 5'b00000, 1));
        vecs.push_back(mk("nan_b",   32'h3F800000, 32'hFFC12345, 32'hFFC12345, 5'b00000, 1));
        vecs.push_back(mk("x/-inf",  32'h3F800000, 32'hFF800000, 32'h80000000, 5'b00000, 1));
        vecs.push_back(mk("-inf/x",  32'hFF800000, 32'h40000000, 32'hFF800000, 5'b00000, 1));
        vecs.push_back(mk("inf/inf", 32'h7F800000, 32'h7F800000, 32'h7FC00000, 5'b10000, 1));
        vecs.push_back(mk("-0/x",    32'h80000000, 32'h3F800000, 32'h80000000, 5'b00000, 1));
        vecs.push_back(mk("-5/2",    32'hC0A00000, 32'h40000000, 32'hC0200000, 5'b00000, LAT_N));
        vecs.push_back(mk("2/3",     32'h40000000, 32'h40400000, 32'h3F2AAAAB, 5'b00001, LAT_N));
        vecs.push_back(mk("1/7",     32'h3F800000, 32'h40E00000, 32'h3E124925, 5'b00001, LAT_N));
        vecs.push_back(mk("1/1",     32'h3F800000, 32'h3F800000, 32'h3F800000, 5'b00000, LAT_N));

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.q", q, 32'd0);
        chk("rst.flags", 32'(flags), 32'd0);
        @(negedge clk);
        clrn = 1'b1;
        @(posedge clk);
        #1;
        chk("rst.in_ready", 32'(in_ready), 32'd1);

        // Table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            e.name = vecs[i].name; e.q = vecs[i].q; e.f = vecs[i].f; e.lat = vecs[i].lat;
            issue(vecs[i].a, vecs[i].b, e);
            collect();
        end

        // Result held in DONE while the consumer stalls
        out_ready = 1'b0;
        e.name = "hold"; e.q = 32'h3EAAAAAB; e.f = 5'b00001; e.lat = LAT_N;
        issue(32'h3F800000, 32'h40400000, e);
        collect();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("hold.q", q, 32'h3EAAAAAB);
            chk("hold.out_valid", 32'(out_valid), 32'd1);
            chk("hold.in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("hold.release_out_valid", 32'(out_valid), 32'd0);
        chk("hold.release_in_ready", 32'(in_ready), 32'd1);

        // Asynchronous reset in the middle of DIV discards the operation
        @(negedge clk);
        a = 32'h40C00000;
        b = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        clrn = 1'b0;
        #1;
        chk("midrst.out_valid", 32'(out_valid), 32'd0);
        chk("midrst.q", q, 32'd0);
        chk("midrst.flags", 32'(flags), 32'd0);
        @(negedge clk);
        @(negedge clk);
        clrn = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst.in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 35; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("midrst.no_stale_result", 32'(seen), 32'd0);

        // Normal operation after the reset
        e.name = "post_rst"; e.q = 32'h40400000; e.f = 5'b00000; e.lat = LAT_N;
        issue(32'h40C00000, 32'h40000000, e);
        collect();

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/float_div_iter.md
FLOAT_DIV_ITER -- requirements
Module: float_div_iter

Interface
REQ-001 SHALL have input clk, 1 bit: rising-edge clock.
REQ-002 SHALL have input clrn, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have input in_valid, 1 bit: operands a, b are present.
REQ-004 SHALL have output in_ready, 1 bit: block can accept operands.
REQ-005 SHALL have input a, 32 bits: IEEE-754 single dividend.
REQ-006 SHALL have input b, 32 bits: IEEE-754 single divisor.
REQ-007 SHALL have output out_valid, 1 bit: q and flags are valid.
REQ-008 SHALL have input out_ready, 1 bit: consumer takes the result.
REQ-009 SHALL have output q, 32 bits: IEEE-754 single quotient a/b.
REQ-010 SHALL have output flags, 5 bits: {nv, dz, of, uf, nx}.

Function
REQ-011 SHALL accept operands on a rising edge where in_valid=1 and in_ready=1; in_ready SHALL be 1 only in state IDLE.
REQ-012 SHALL implement the FSM states IDLE, NORM (macro only), DIV, ROUND and DONE.
REQ-013 SHALL take these transitions:
- On acceptance, IDLE->NORM/DIV.
- On acceptance of special operands, IDLE->DONE.
- NORM->DIV after 1 cycle.
- DIV->ROUND after exactly 26 iterations.
- ROUND->DONE.
- DONE->IDLE on out_ready=1.
REQ-014 SHALL compute sign = a[31]^b[31] and exp = ea-eb+127 as a 10-bit two's complement value.
REQ-015 SHALL, when mantissa(a)<mantissa(b), pre-shift the dividend left by 1 and decrement exp.
REQ-016 SHALL run DIV as a radix-2 restoring divide producing 1 quotient bit per cycle, 26 bits total (24 + guard + round); a nonzero final remainder SHALL set sticky.
REQ-017 SHALL round to nearest, ties to even; a mantissa carry-out SHALL increment exp.
REQ-018 SHALL produce +/-inf with of=1 and nx=1 when exp>=255 after rounding.
REQ-019 SHALL set nx=1 whenever guard|round|sticky=1.
REQ-020 SHALL treat these as special operands, resolved without DIV:
- Either NaN -> {sign,8'hff,1,frac[21:0] of a if a is NaN else of b}.
- 0/0 or inf/inf -> 32'h7FC00000 with nv=1.
- finite nonzero/0 -> signed inf with dz=1.
- inf/finite -> signed inf.
- 0/finite nonzero or finite/inf -> signed zero.
REQ-021 SHALL raise out_valid 27 cycles after the acceptance edge (28 with the macro) and 1 cycle after for special operands.
REQ-022 SHALL hold q, flags and out_valid stable in DONE while out_ready=0.
REQ-023 SHALL ignore in_valid while not in IDLE; operands SHALL be captured only at acceptance.
REQ-024 SHALL register all outputs.

Reset
REQ-025 SHALL, on clrn=0 at any time including mid-DIV, force state=IDLE, out_valid=0, q=0, flags=0 and all internal counters to 0, and discard any operation in flight.
REQ-026 SHALL, after clrn deasserts, set in_ready=1 from the first cycle.

Configuration
REQ-027 SHALL use macro FDIV_SUBNORMAL_EN.
- Defined: NORM state left-normalizes subnormal mantissas with a leading-zero count and adjusts exp. Results with exp<=0 are right-shifted into a subnormal with sticky preserved, then rounded. uf=1 if tiny and inexact.
- Undefined: NORM is absent. Subnormal inputs are treated as signed zero. Results with exp<=0 are flushed to signed zero with uf=1 and nx=1.

Verification
REQ-028 SHALL cover: 40C00000/40000000 -> q=40400000, flags=0, out_valid exactly 27 cycles after accept (28 with macro).
REQ-029 SHALL cover: 3F800000/40400000 -> q=3EAAAAAB, flags=00001.
REQ-030 SHALL cover: 3F800000/00000000 -> q=7F800000, flags=01000, 1-cycle latency; 00000000/00000000 -> q=7FC00000, flags=10000.
REQ-031 SHALL cover: 7F7FFFFF/3F000000 -> q=7F800000, flags=00101.
REQ-032 SHALL cover: 00800000/40000000 -> with macro q=00400000, flags=0; without macro q=00000000, flags=00011.
REQ-033 SHALL cover: hold out_ready=0 for 10 cycles in DONE -> q stable, in_ready=0; then clrn=0 pulsed mid-DIV of a new operation -> out_valid=0, q=0, in_ready=1 after release.
